// File: rtl/raster_engine.sv
// raster_engine: draws FILL / POINT / RECT / LINE primitives into a
// framebuffer through a write port with ready backpressure. One candidate
// pixel is visited per cycle. Pixels outside the framebuffer are skipped
// without waiting for the framebuffer.

package common;
    typedef enum logic [1:0] {
        RASTER_CMD_FILL  = 2'd0,
        RASTER_CMD_POINT = 2'd1,
        RASTER_CMD_LINE  = 2'd2,
        RASTER_CMD_RECT  = 2'd3
    } raster_command_t;
endpackage

module raster_engine #(
    parameter int FB_WIDTH  = 160,
    parameter int FB_HEIGHT = 120,
    parameter int ADDR_W    = 15
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  common::raster_command_t gpu_command,
    input  logic [7:0]              gpu_x0,
    input  logic [7:0]              gpu_y0,
    input  logic [7:0]              gpu_x1,
    input  logic [7:0]              gpu_y1,
    input  logic [2:0]              gpu_colour,
    input  logic                    gpu_execute_request,
    output logic                    gpu_busy,
    output logic [ADDR_W-1:0]       fb_addr,
    output logic [2:0]              fb_data,
    output logic                    fb_write,
    input  logic                    fb_ready
);

    typedef enum logic [1:0] {ST_IDLE, ST_SCAN, ST_LINE} state_t;

    localparam logic [8:0]        X_LIMIT    = 9'(FB_WIDTH);
    localparam logic [8:0]        Y_LIMIT    = 9'(FB_HEIGHT);
    localparam logic [8:0]        X_LAST     = 9'(FB_WIDTH - 1);
    localparam logic [8:0]        Y_LAST     = 9'(FB_HEIGHT - 1);
    localparam logic [ADDR_W-1:0] ROW_STRIDE = ADDR_W'(FB_WIDTH);

    // Absolute difference of two unsigned 8-bit coordinates.
    function automatic logic [7:0] abs_diff(input logic [7:0] a, input logic [7:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    state_t r_state;
    state_t w_state_next;

    // Iterators are 9 bits so stepping past 255 never wraps back on screen.
    logic [8:0]         r_x;
    logic [8:0]         r_y;
    logic [8:0]         r_xmin;
    logic [8:0]         r_xmax;
    logic [8:0]         r_ymax;
    logic [8:0]         r_x1;
    logic [8:0]         r_y1;
    logic               r_sx_neg;
    logic               r_sy_neg;
    logic signed [11:0] r_dx;
    logic signed [11:0] r_dy;
    logic signed [11:0] r_err;
    logic [2:0]         r_colour;

    logic               w_accept;
    logic               w_is_line;
    logic               w_in_range;
    logic               w_advance;
    logic               w_scan_last;
    logic               w_line_last;
    logic               w_last;
    logic [8:0]         w_start_xmin;
    logic [8:0]         w_start_xmax;
    logic [8:0]         w_start_ymin;
    logic [8:0]         w_start_ymax;
    logic [7:0]         w_abs_dx;
    logic [7:0]         w_abs_dy;
    logic signed [11:0] w_e2;
    logic               w_step_x;
    logic               w_step_y;
    logic signed [11:0] w_err_next;

    assign w_accept    = (r_state == ST_IDLE) && gpu_execute_request;
    assign w_is_line   = (gpu_command == common::RASTER_CMD_LINE);
    assign w_in_range  = (r_x < X_LIMIT) && (r_y < Y_LIMIT);
    // Clipped pixels move on without waiting for the framebuffer.
    assign w_advance   = (r_state != ST_IDLE) && (!w_in_range || fb_ready);
    assign w_scan_last = (r_x == r_xmax) && (r_y == r_ymax);
    assign w_line_last = (r_x == r_x1) && (r_y == r_y1);
    assign w_last      = (r_state == ST_LINE) ? w_line_last : w_scan_last;

    assign w_abs_dx    = abs_diff(gpu_x0, gpu_x1);
    assign w_abs_dy    = abs_diff(gpu_y0, gpu_y1);

    assign gpu_busy    = (r_state != ST_IDLE);
    assign fb_write    = gpu_busy && w_in_range;
    assign fb_data     = r_colour;
    assign fb_addr     = ADDR_W'(r_y) * ROW_STRIDE + ADDR_W'(r_x);

    // Scan bounds for the command being accepted.
    always_comb begin
        w_start_xmin = {1'b0, gpu_x0};
        w_start_xmax = {1'b0, gpu_x0};
        w_start_ymin = {1'b0, gpu_y0};
        w_start_ymax = {1'b0, gpu_y0};
        case (gpu_command)
            common::RASTER_CMD_FILL: begin
                w_start_xmin = 9'd0;
                w_start_xmax = X_LAST;
                w_start_ymin = 9'd0;
                w_start_ymax = Y_LAST;
            end
            common::RASTER_CMD_RECT: begin
                w_start_xmin = {1'b0, (gpu_x0 <= gpu_x1) ? gpu_x0 : gpu_x1};
                w_start_xmax = {1'b0, (gpu_x0 <= gpu_x1) ? gpu_x1 : gpu_x0};
                w_start_ymin = {1'b0, (gpu_y0 <= gpu_y1) ? gpu_y0 : gpu_y1};
                w_start_ymax = {1'b0, (gpu_y0 <= gpu_y1) ? gpu_y1 : gpu_y0};
            end
            default: begin
                w_start_xmin = {1'b0, gpu_x0};
                w_start_xmax = {1'b0, gpu_x0};
                w_start_ymin = {1'b0, gpu_y0};
                w_start_ymax = {1'b0, gpu_y0};
            end
        endcase
    end

    // Bresenham step decision; r_dy holds -|dy| so both tests are plain compares.
    always_comb begin
        w_e2       = r_err <<< 1;
        w_step_x   = (w_e2 >= r_dy);
        w_step_y   = (w_e2 <= r_dx);
        w_err_next = r_err;
        if (w_step_x) begin
            w_err_next = w_err_next + r_dy;
        end
        if (w_step_y) begin
            w_err_next = w_err_next + r_dx;
        end
    end

    // State register; reset wins over a simultaneous request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: leave a drawing state once the final pixel is done.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = w_is_line ? ST_LINE : ST_SCAN;
                end
            end
            ST_SCAN: begin
                if (w_advance && w_scan_last) begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_LINE: begin
                if (w_advance && w_line_last) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // Command latch at accept, then iterator stepping while drawing.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_x      <= 9'd0;
            r_y      <= 9'd0;
            r_xmin   <= 9'd0;
            r_xmax   <= 9'd0;
            r_ymax   <= 9'd0;
            r_x1     <= 9'd0;
            r_y1     <= 9'd0;
            r_sx_neg <= 1'b0;
            r_sy_neg <= 1'b0;
            r_dx     <= 12'sd0;
            r_dy     <= 12'sd0;
            r_err    <= 12'sd0;
            r_colour <= 3'd0;
        end else if (w_accept) begin
            r_colour <= gpu_colour;
            r_xmin   <= w_start_xmin;
            r_xmax   <= w_start_xmax;
            r_ymax   <= w_start_ymax;
            r_x1     <= {1'b0, gpu_x1};
            r_y1     <= {1'b0, gpu_y1};
            r_sx_neg <= (gpu_x1 < gpu_x0);
            r_sy_neg <= (gpu_y1 < gpu_y0);
            r_dx     <= $signed({4'b0000, w_abs_dx});
            r_dy     <= -$signed({4'b0000, w_abs_dy});
            r_err    <= $signed({4'b0000, w_abs_dx}) - $signed({4'b0000, w_abs_dy});
            r_x      <= w_is_line ? {1'b0, gpu_x0} : w_start_xmin;
            r_y      <= w_is_line ? {1'b0, gpu_y0} : w_start_ymin;
        end else if (w_advance && !w_last) begin
            if (r_state == ST_LINE) begin
                if (w_step_x) begin
                    r_x <= r_sx_neg ? (r_x - 9'd1) : (r_x + 9'd1);
                end
                if (w_step_y) begin
                    r_y <= r_sy_neg ? (r_y - 9'd1) : (r_y + 9'd1);
                end
                r_err <= w_err_next;
            end else begin
                if (r_x == r_xmax) begin
                    r_x <= r_xmin;
                    r_y <= r_y + 9'd1;
                end else begin
                    r_x <= r_x + 9'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_raster_engine.sv
// Directed testbench for raster_engine: reset, POINT, RECT, LINE octants,
// degenerate shapes, clipping, FILL under backpressure, reset abort and
// back-to-back commands.
module tb_raster_engine;
    import common::*;

    localparam int W  = 160;
    localparam int H  = 120;
    localparam int AW = 15;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    raster_command_t cmd = RASTER_CMD_FILL;
    logic [7:0]      x0 = 8'd0;
    logic [7:0]      y0 = 8'd0;
    logic [7:0]      x1 = 8'd0;
    logic [7:0]      y1 = 8'd0;
    logic [2:0]      col = 3'd0;
    logic            exec = 1'b0;
    logic            busy;
    logic [AW-1:0]   addr;
    logic [2:0]      data;
    logic            wr;
    logic            ready = 1'b1;

    int checks = 0;
    int failures = 0;

    int wa[$];
    int wd[$];
    int busy_cyc;
    int stall_err;
    bit timed_out;
    logic busy_first;

    // LINE cases: endpoints, colour, pixel count and expected addresses.
    int lx0[5] = '{0, 5, 3, 7, 20};
    int ly0[5] = '{0, 2, 0, 3, 10};
    int lx1[5] = '{5, 0, 0, 2, 20};
    int ly1[5] = '{2, 0, 7, 3, 13};
    int lcol[5] = '{3, 3, 2, 5, 4};
    int lcnt[5] = '{6, 6, 8, 6, 4};
    int line_exp[5][8] = '{
        '{0, 1, 162, 163, 324, 325, 0, 0},
        '{325, 324, 163, 162, 1, 0, 0, 0},
        '{3, 163, 322, 482, 641, 801, 960, 1120},
        '{487, 486, 485, 484, 483, 482, 0, 0},
        '{1620, 1780, 1940, 2100, 0, 0, 0, 0}
    };

    raster_engine #(.FB_WIDTH(W), .FB_HEIGHT(H), .ADDR_W(AW)) dut (
        .clk                (clk),
        .rst_n              (rst_n),
        .gpu_command        (cmd),
        .gpu_x0             (x0),
        .gpu_y0             (y0),
        .gpu_x1             (x1),
        .gpu_y1             (y1),
        .gpu_colour         (col),
        .gpu_execute_request(exec),
        .gpu_busy           (busy),
        .fb_addr            (addr),
        .fb_data            (data),
        .fb_write           (wr),
        .fb_ready           (ready)
    );

    always #5 clk = ~clk;

    // Issue one command (called at a falling edge) and collect accepted
    // writes until busy drops. rmode 1 randomises fb_ready. pulse_at >= 0
    // fires a second request with altered inputs at that busy cycle.
    task automatic run_cmd(input raster_command_t c, input int ax0, input int ay0,
                           input int ax1, input int ay1, input int acol,
                           input int rmode, input int pulse_at, input int limit);
        int n;
        logic [AW-1:0] paddr;
        logic [2:0] pdata;
        bit pstall;
        wa.delete();
        wd.delete();
        busy_cyc = 0;
        stall_err = 0;
        timed_out = 0;
        pstall = 0;
        paddr = '0;
        pdata = '0;
        cmd = c;
        x0 = 8'(ax0);
        y0 = 8'(ay0);
        x1 = 8'(ax1);
        y1 = 8'(ay1);
        col = 3'(acol);
        exec = 1'b1;
        ready = 1'b1;
        @(negedge clk);
        exec = 1'b0;
        busy_first = busy;
        n = 0;
        while (busy === 1'b1 && n < limit) begin
            if (pstall && !(wr === 1'b1 && addr === paddr && data === pdata)) stall_err++;
            if (rmode == 1) ready = ($urandom_range(0, 3) != 0);
            else ready = 1'b1;
            if (n == pulse_at) begin
                exec = 1'b1;
                cmd = RASTER_CMD_POINT;
                x0 = 8'd0;
                y0 = 8'd0;
                col = ~col;
            end else begin
                exec = 1'b0;
            end
            if (wr === 1'b1 && ready) begin
                wa.push_back(int'(addr));
                wd.push_back(int'(data));
            end
            pstall = (wr === 1'b1) && !ready;
            paddr = addr;
            pdata = data;
            busy_cyc++;
            n++;
            @(negedge clk);
        end
        exec = 1'b0;
        ready = 1'b1;
        if (n >= limit) timed_out = 1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        exec = 1'b1;
        cmd = RASTER_CMD_POINT;
        x0 = 8'd5;
        y0 = 8'd5;
        repeat (3) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (wr !== 1'b0) begin failures++; $display("FAIL reset_write: got %b expected 0", wr); end
        checks++; if (addr !== '0) begin failures++; $display("FAIL reset_addr: got %0d expected 0", addr); end
        checks++; if (data !== 3'd0) begin failures++; $display("FAIL reset_data: got %0d expected 0", data); end
        exec = 1'b0;
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_idle_after: got %b expected 0", busy); end
    endtask

    task automatic test_point();
        run_cmd(RASTER_CMD_POINT, 100, 100, 0, 0, 6, 0, -1, 100);
        checks++; if (timed_out) begin failures++; $display("FAIL point_timeout: got 1 expected 0"); end
        checks++; if (busy_first !== 1'b1) begin failures++; $display("FAIL point_busy_start: got %b expected 1", busy_first); end
        checks++; if (wa.size() != 1) begin failures++; $display("FAIL point_count: got %0d expected 1", wa.size()); end
        if (wa.size() > 0) begin
            checks++; if (wa[0] != 16100) begin failures++; $display("FAIL point_addr: got %0d expected 16100", wa[0]); end
            checks++; if (wd[0] != 6) begin failures++; $display("FAIL point_data: got %0d expected 6", wd[0]); end
        end
        checks++; if (busy_cyc != 1) begin failures++; $display("FAIL point_busy_cycles: got %0d expected 1", busy_cyc); end
    endtask

    task automatic test_rect();
        int exp_a[$];
        int de;
        for (int yy = 5; yy <= 7; yy++)
            for (int xx = 10; xx <= 12; xx++)
                exp_a.push_back(yy * W + xx);
        run_cmd(RASTER_CMD_RECT, 12, 7, 10, 5, 5, 0, -1, 100);
        checks++; if (timed_out) begin failures++; $display("FAIL rect_timeout: got 1 expected 0"); end
        checks++; if (wa.size() != 9) begin failures++; $display("FAIL rect_count: got %0d expected 9", wa.size()); end
        checks++; if (busy_cyc != 9) begin failures++; $display("FAIL rect_busy_cycles: got %0d expected 9", busy_cyc); end
        for (int i = 0; i < 9; i++) begin
            if (i < wa.size()) begin
                checks++; if (wa[i] != exp_a[i]) begin failures++; $display("FAIL rect_addr%0d: got %0d expected %0d", i, wa[i], exp_a[i]); end
            end
        end
        de = 0;
        foreach (wd[i]) if (wd[i] != 5) de++;
        checks++; if (de != 0) begin failures++; $display("FAIL rect_data: got %0d bad colours expected 0", de); end
    endtask

    task automatic test_line();
        int de;
        for (int k = 0; k < 5; k++) begin
            run_cmd(RASTER_CMD_LINE, lx0[k], ly0[k], lx1[k], ly1[k], lcol[k], 0, -1, 100);
            checks++; if (timed_out) begin failures++; $display("FAIL line%0d_timeout: got 1 expected 0", k); end
            checks++; if (wa.size() != lcnt[k]) begin failures++; $display("FAIL line%0d_count: got %0d expected %0d", k, wa.size(), lcnt[k]); end
            checks++; if (busy_cyc != lcnt[k]) begin failures++; $display("FAIL line%0d_busy_cycles: got %0d expected %0d", k, busy_cyc, lcnt[k]); end
            for (int i = 0; i < lcnt[k]; i++) begin
                if (i < wa.size()) begin
                    checks++; if (wa[i] != line_exp[k][i]) begin failures++; $display("FAIL line%0d_addr%0d: got %0d expected %0d", k, i, wa[i], line_exp[k][i]); end
                end
            end
            de = 0;
            foreach (wd[i]) if (wd[i] != lcol[k]) de++;
            checks++; if (de != 0) begin failures++; $display("FAIL line%0d_data: got %0d bad colours expected 0", k, de); end
        end
    endtask

    task automatic test_degenerate();
        run_cmd(RASTER_CMD_RECT, 4, 4, 4, 4, 2, 0, -1, 100);
        checks++; if (wa.size() != 1) begin failures++; $display("FAIL degen_rect_count: got %0d expected 1", wa.size()); end
        if (wa.size() > 0) begin
            checks++; if (wa[0] != 644) begin failures++; $display("FAIL degen_rect_addr: got %0d expected 644", wa[0]); end
        end
        checks++; if (busy_cyc != 1) begin failures++; $display("FAIL degen_rect_busy: got %0d expected 1", busy_cyc); end
        run_cmd(RASTER_CMD_LINE, 9, 9, 9, 9, 7, 0, -1, 100);
        checks++; if (wa.size() != 1) begin failures++; $display("FAIL degen_line_count: got %0d expected 1", wa.size()); end
        if (wa.size() > 0) begin
            checks++; if (wa[0] != 1449) begin failures++; $display("FAIL degen_line_addr: got %0d expected 1449", wa[0]); end
        end
        checks++; if (busy_cyc != 1) begin failures++; $display("FAIL degen_line_busy: got %0d expected 1", busy_cyc); end
    endtask

    task automatic test_clip();
        int exp_a[4] = '{19038, 19039, 19198, 19199};
        run_cmd(RASTER_CMD_RECT, 158, 118, 161, 121, 3, 0, -1, 100);
        checks++; if (timed_out) begin failures++; $display("FAIL clip_timeout: got 1 expected 0"); end
        checks++; if (busy_cyc != 16) begin failures++; $display("FAIL clip_cycles: got %0d expected 16", busy_cyc); end
        checks++; if (wa.size() != 4) begin failures++; $display("FAIL clip_count: got %0d expected 4", wa.size()); end
        for (int i = 0; i < 4; i++) begin
            if (i < wa.size()) begin
                checks++; if (wa[i] != exp_a[i]) begin failures++; $display("FAIL clip_addr%0d: got %0d expected %0d", i, wa[i], exp_a[i]); end
            end
        end
    endtask

    task automatic test_fill_stall();
        int bad_idx;
        int de;
        int late;
        run_cmd(RASTER_CMD_FILL, 50, 60, 70, 80, 1, 1, 500, 60000);
        checks++; if (timed_out) begin failures++; $display("FAIL fill_timeout: got 1 expected 0"); end
        checks++; if (wa.size() != W * H) begin failures++; $display("FAIL fill_count: got %0d expected %0d", wa.size(), W * H); end
        bad_idx = -1;
        foreach (wa[i]) if (bad_idx < 0 && wa[i] != i) bad_idx = i;
        checks++; if (bad_idx != -1) begin failures++; $display("FAIL fill_order: first out-of-order index %0d expected none (-1)", bad_idx); end
        de = 0;
        foreach (wd[i]) if (wd[i] != 1) de++;
        checks++; if (de != 0) begin failures++; $display("FAIL fill_data: got %0d bad colours expected 0", de); end
        checks++; if (stall_err != 0) begin failures++; $display("FAIL fill_stall_stable: got %0d unstable cycles expected 0", stall_err); end
        checks++; if (busy_cyc <= W * H) begin failures++; $display("FAIL fill_backpressure: got %0d busy cycles expected more than %0d", busy_cyc, W * H); end
        late = 0;
        repeat (4) begin
            if (busy !== 1'b0 || wr !== 1'b0) late++;
            @(negedge clk);
        end
        checks++; if (late != 0) begin failures++; $display("FAIL fill_overlap_ignored: got %0d busy cycles after fill expected 0", late); end
    endtask

    task automatic test_reset_mid();
        int n;
        int post_wr;
        cmd = RASTER_CMD_FILL;
        col = 3'd2;
        exec = 1'b1;
        ready = 1'b1;
        @(negedge clk);
        exec = 1'b0;
        n = 0;
        while (!(wr === 1'b1 && addr == 49) && n < 200) begin
            n++;
            @(negedge clk);
        end
        checks++; if (n >= 200) begin failures++; $display("FAIL rstmid_reach_pixel50: got timeout expected addr 49"); end
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rstmid_busy: got %b expected 0", busy); end
        checks++; if (wr !== 1'b0) begin failures++; $display("FAIL rstmid_write: got %b expected 0", wr); end
        checks++; if (addr !== '0) begin failures++; $display("FAIL rstmid_addr: got %0d expected 0", addr); end
        post_wr = 0;
        repeat (5) begin
            @(negedge clk);
            if (wr !== 1'b0 || busy !== 1'b0) post_wr++;
        end
        checks++; if (post_wr != 0) begin failures++; $display("FAIL rstmid_no_replay: got %0d active cycles expected 0", post_wr); end
        run_cmd(RASTER_CMD_POINT, 0, 0, 0, 0, 7, 0, -1, 100);
        checks++; if (wa.size() != 1) begin failures++; $display("FAIL rstmid_point_count: got %0d expected 1", wa.size()); end
        if (wa.size() > 0) begin
            checks++; if (wa[0] != 0) begin failures++; $display("FAIL rstmid_point_addr: got %0d expected 0", wa[0]); end
            checks++; if (wd[0] != 7) begin failures++; $display("FAIL rstmid_point_data: got %0d expected 7", wd[0]); end
        end
        checks++; if (busy_cyc != 1) begin failures++; $display("FAIL rstmid_point_busy: got %0d expected 1", busy_cyc); end
    endtask

    task automatic test_back_to_back();
        run_cmd(RASTER_CMD_POINT, 1, 2, 0, 0, 3, 0, -1, 100);
        checks++; if (wa.size() != 1) begin failures++; $display("FAIL b2b_first_count: got %0d expected 1", wa.size()); end
        if (wa.size() > 0) begin
            checks++; if (wa[0] != 321) begin failures++; $display("FAIL b2b_first_addr: got %0d expected 321", wa[0]); end
        end
        run_cmd(RASTER_CMD_POINT, 2, 1, 0, 0, 4, 0, -1, 100);
        checks++; if (busy_first !== 1'b1) begin failures++; $display("FAIL b2b_second_accept: got %b expected 1", busy_first); end
        checks++; if (wa.size() != 1) begin failures++; $display("FAIL b2b_second_count: got %0d expected 1", wa.size()); end
        if (wa.size() > 0) begin
            checks++; if (wa[0] != 162) begin failures++; $display("FAIL b2b_second_addr: got %0d expected 162", wa[0]); end
            checks++; if (wd[0] != 4) begin failures++; $display("FAIL b2b_second_data: got %0d expected 4", wd[0]); end
        end
    endtask

    initial begin
        test_reset();
        test_point();
        test_rect();
        test_line();
        test_degenerate();
        test_clip();
        test_fill_stall();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/raster_engine.md
RASTER_ENGINE -- requirements
Module: raster_engine

Interface
REQ-001 Parameter FB_WIDTH, default 160, meaning framebuffer width in pixels; valid range 1..256.
REQ-002 Parameter FB_HEIGHT, default 120, meaning framebuffer height in pixels; valid range 1..256.
REQ-003 Parameter ADDR_W, default 15, meaning framebuffer address width; must satisfy 2^ADDR_W >= FB_WIDTH*FB_HEIGHT.
REQ-004 One clock; reset is synchronous and active-low.
REQ-005 clk  input  1  system clock, 50MHz; all state changes on the rising edge.
REQ-006 rst_n  input  1  synchronous active-low reset.
REQ-007 gpu_command  input  common::raster_command_t  command to run: RASTER_CMD_FILL, RASTER_CMD_POINT, RASTER_CMD_LINE or RASTER_CMD_RECT.
REQ-008 gpu_x0, gpu_y0, gpu_x1, gpu_y1  input  8 each  unsigned pixel coordinates.
REQ-009 gpu_colour  input  3  pixel colour to draw.
REQ-010 gpu_execute_request  input  1  one-cycle strobe that starts a command.
REQ-011 gpu_busy  output  1  high while a command is executing.
REQ-012 fb_addr  output  ADDR_W  write address, equal to y*FB_WIDTH + x.
REQ-013 fb_data  output  3  write colour.
REQ-014 fb_write  output  1  write strobe.
REQ-015 fb_ready  input  1  framebuffer accepts a write in any cycle where fb_write and fb_ready are both high.

Function
REQ-016 Three states: IDLE, SCAN (covers FILL, POINT and RECT) and LINE.
REQ-017 In IDLE, gpu_execute_request=1 causes all gpu_* inputs to be latched, and busy becomes 1 on the next cycle; the latched values are used for the whole command.
REQ-018 gpu_execute_request while busy is ignored; input changes while busy have no effect.
REQ-019 POINT draws the single pixel (x0,y0).
REQ-020 RECT draws a filled, inclusive rectangle spanning x from min(x0,x1) to max(x0,x1) and y from min(y0,y1) to max(y0,y1).
REQ-021 RECT pixels are produced in row-major order: x increments fastest, then y.
REQ-022 FILL draws every pixel from (0,0) to (FB_WIDTH-1, FB_HEIGHT-1) in row-major order; it ignores the coordinate inputs.
REQ-023 LINE uses Bresenham over all 8 octants, starts at (x0,y0) and ends at (x1,y1), and includes both endpoints.
REQ-024 LINE steps along the major axis, producing max(|dx|,|dy|)+1 pixels.
REQ-025 LINE uses a signed error term at least 10 bits wide, so no overflow is possible for 8-bit coordinates.
REQ-026 The engine visits one candidate pixel per cycle while fb_ready=1.
REQ-027 When fb_write=1 and fb_ready=0, fb_addr, fb_data and fb_write hold stable and the iteration does not advance.
REQ-028 A pixel with x>=FB_WIDTH or y>=FB_HEIGHT is clipped: fb_write=0 for that cycle, and the iterator still advances one cycle.
REQ-029 fb_write is never asserted in IDLE.
REQ-030 fb_data always equals the latched colour.
REQ-031 busy drops to 0 in the cycle after the last pixel's write is accepted (or after the last pixel is clipped), and the state returns to IDLE at the same time.
REQ-032 A new request is accepted in the cycle after busy drops, or later.
REQ-033 Cycle count from accept to busy falling, with fb_ready held at 1, is the pixel count + 1: POINT takes 2 cycles.
REQ-034 Degenerate cases:
- RECT or LINE with x0=x1 and y0=y1 draws exactly one pixel.
- Horizontal and vertical lines are handled without special-casing errors.
REQ-035 The x and y iterators are 9 bits wide internally, so incrementing past 255 does not wrap back into range.

Reset
REQ-036 When rst_n=0 at a clock edge, the state becomes IDLE and gpu_busy=0, fb_write=0, fb_addr=0, fb_data=0 on the next cycle.
REQ-037 Reset during SCAN or LINE aborts the command immediately; no further writes occur and nothing is replayed.
REQ-038 Reset has priority over a simultaneous gpu_execute_request.

Verification
REQ-039 POINT scenario: POINT (100,100) colour 6 with fb_ready=1 -> exactly one write, addr 16100, data 6; busy high for exactly 1 cycle.
REQ-040 RECT scenario: RECT x0=12 y0=7 x1=10 y1=5 colour 5 -> 9 writes in order (10,5),(11,5),(12,5),(10,6)...(12,7); first addr 810, last addr 1132.
REQ-041 LINE scenario: LINE (0,0)->(5,2) colour 3 -> pixels (0,0),(1,0),(2,1),(3,1),(4,2),(5,2). A second run with the endpoints reversed -> the mirrored pixel set, same count.
REQ-042 Stall and overlap scenario: FILL colour 1 with fb_ready toggled randomly -> exactly 19200 accepted writes, addr 0..19199 each exactly once and in order, and fb outputs stable during stalls. A second execute_request pulsed mid-FILL is ignored.
REQ-043 Clipping scenario: RECT (158,118)->(161,121) -> 16 candidate cycles; writes only to (158,118),(159,118),(158,119),(159,119).
REQ-044 Reset scenario: assert rst_n=0 during the 50th FILL pixel -> next cycle busy=0 and fb_write=0; a following POINT (0,0) runs normally.
